// File: rtl/beat_pkg.sv
// Shared definitions for the beat/BPM estimator: FSM state encoding,
// tempo-derived tick limits and the fixed onset-to-estimate divider latency.
package beat_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_LOW,
    S_HIGH
  } state_t;

  localparam int DIV_LATENCY = 16;

  function automatic int calc_min_ticks(input int ticks_per_min, input int max_bpm);
    return ticks_per_min / max_bpm;
  endfunction

  function automatic int calc_max_ticks(input int ticks_per_min, input int min_bpm);
    return ticks_per_min / min_bpm;
  endfunction

endpackage

// File: rtl/bpm_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, fixed NUM_W iterations
// after the load cycle. A start while busy is ignored; divide-by-0 yields all-ones.
module bpm_divider #(
  parameter int NUM_W = 14,
  parameter int DEN_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quot
);

  localparam int CW = $clog2(NUM_W + 1);

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NUM_W-1:0] quot_q, quot_d;
  logic [DEN_W-1:0] rem_q, rem_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [DEN_W:0]   shifted;
  logic [DEN_W:0]   trial;

  always_comb begin
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    den_d   = den_q;
    shifted = {rem_q, quot_q[NUM_W-1]};
    trial   = shifted - {1'b0, den_q};
    if (!busy_q) begin
      if (start) begin
        busy_d = 1'b1;
        cnt_d  = CW'(NUM_W);
        quot_d = num;
        rem_d  = '0;
        den_d  = den;
      end
    end else begin
      // The quotient register doubles as the dividend shift register.
      if (shifted >= {1'b0, den_q}) begin
        rem_d  = trial[DEN_W-1:0];
        quot_d = {quot_q[NUM_W-2:0], 1'b1};
      end else begin
        rem_d  = shifted[DEN_W-1:0];
        quot_d = {quot_q[NUM_W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      den_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign quot = quot_q;

endmodule

// File: rtl/beat_bpm_estimator.sv
// Beat onset detector with hysteresis/refractory window and interval-to-BPM conversion.
// Optional BEAT_BPM_SMOOTH_EN blends each new quotient into the running estimate.
module beat_bpm_estimator
  import beat_pkg::*;
#(
  parameter int BITS          = 8,
  parameter int MIN_BPM       = 40,
  parameter int MAX_BPM       = 200,
  parameter int TICK_DIV      = 200_000,
  parameter int TICKS_PER_MIN = 15000,
  parameter int THRESH_HI     = 128,
  parameter int THRESH_LO     = 96
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [BITS-1:0]              mag_in,
  input  logic                         mag_valid,
  output logic                         mag_ready,
  output logic [$clog2(MAX_BPM+1)-1:0] BPM_estimate,
  output logic                         bpm_valid,
  output logic [BITS-1:0]              pulse_amplitude,
  output logic                         beat_pulse,
  output logic                         bpm_update
);

  localparam int BW        = $clog2(MAX_BPM + 1);
  localparam int TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW        = 10;
  localparam int DEN_W     = 9;
  // Start register + load cycle + one cycle per quotient bit.
  localparam int NUM_W     = DIV_LATENCY - 2;
  localparam int MIN_TICKS = calc_min_ticks(TICKS_PER_MIN, MAX_BPM);
  localparam int MAX_TICKS = calc_max_ticks(TICKS_PER_MIN, MIN_BPM);

  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [IW-1:0]    MIN_T     = IW'(MIN_TICKS);
  localparam logic [IW-1:0]    SAT_T     = IW'(MAX_TICKS + 1);
  localparam logic [BITS-1:0]  HI        = BITS'(THRESH_HI);
  localparam logic [BITS-1:0]  LO        = BITS'(THRESH_LO);
  localparam logic [NUM_W-1:0] MIN_Q     = NUM_W'(MIN_BPM);
  localparam logic [NUM_W-1:0] MAX_Q     = NUM_W'(MAX_BPM);

  function automatic logic [BW-1:0] clamp_bpm(input logic [NUM_W-1:0] v);
    if (v < MIN_Q) return BW'(MIN_BPM);
    if (v > MAX_Q) return BW'(MAX_BPM);
    return v[BW-1:0];
  endfunction

  state_t            state_q, state_d;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [IW-1:0]     interval_cnt_q, interval_cnt_d;
  logic [BITS-1:0]   peak_q, peak_d;
  logic [BITS-1:0]   pulse_amp_q, pulse_amp_d;
  logic              beat_pulse_q, beat_pulse_d;
  logic              div_start_q, div_start_d;
  logic [DEN_W-1:0]  div_den_q, div_den_d;
  logic [BW-1:0]     bpm_q, bpm_d;
  logic              bpm_valid_q, bpm_valid_d;
  logic              bpm_update_q, bpm_update_d;
  logic              mag_ready_q;
  logic              tick;
  logic              timeout;
  logic              div_busy, div_done;
  logic [NUM_W-1:0]  div_quot;

`ifdef BEAT_BPM_SMOOTH_EN
  logic              sm_go_q, sm_go_d;
  logic [BW-1:0]     sm_val_q, sm_val_d;
  logic [BW+1:0]     blend_sum;
`endif

  bpm_divider #(
    .NUM_W (NUM_W),
    .DEN_W (DEN_W)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .start (div_start_q && !div_busy),
    .num   (NUM_W'(TICKS_PER_MIN)),
    .den   (div_den_q),
    .busy  (div_busy),
    .done  (div_done),
    .quot  (div_quot)
  );

  always_comb begin
    tick           = (tick_cnt_q == TICK_LAST);
    tick_cnt_d     = tick ? '0 : tick_cnt_q + TW'(1);
    interval_cnt_d = interval_cnt_q;
    if (tick && interval_cnt_q != SAT_T) interval_cnt_d = interval_cnt_q + IW'(1);
    state_d      = state_q;
    peak_d       = peak_q;
    pulse_amp_d  = pulse_amp_q;
    beat_pulse_d = 1'b0;
    div_start_d  = 1'b0;
    div_den_d    = div_den_q;
    bpm_d        = bpm_q;
    bpm_valid_d  = bpm_valid_q;
    bpm_update_d = 1'b0;
    timeout      = (state_q == S_LOW || state_q == S_HIGH) && interval_cnt_q == SAT_T;

    if (timeout) begin
      state_d     = S_IDLE;
      bpm_valid_d = 1'b0;
    end else if (mag_valid) begin
      unique case (state_q)
        S_IDLE: if (mag_in < LO) state_d = S_ARM;
        S_ARM: begin
          if (mag_in >= HI) begin
            beat_pulse_d   = 1'b1;
            interval_cnt_d = '0;
            peak_d         = mag_in;
            state_d        = S_HIGH;
          end
        end
        S_LOW: begin
          // Onsets inside the refractory window are dropped; the interval keeps running.
          if (mag_in >= HI && interval_cnt_q >= MIN_T) begin
            beat_pulse_d   = 1'b1;
            div_den_d      = interval_cnt_q[DEN_W-1:0];
            div_start_d    = 1'b1;
            interval_cnt_d = '0;
            peak_d         = mag_in;
            state_d        = S_HIGH;
          end
        end
        S_HIGH: begin
          if (mag_in > peak_q) peak_d = mag_in;
          if (mag_in < LO) begin
            pulse_amp_d = peak_d;
            state_d     = S_LOW;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

`ifdef BEAT_BPM_SMOOTH_EN
    sm_go_d   = div_done;
    sm_val_d  = div_done ? clamp_bpm(div_quot) : sm_val_q;
    blend_sum = {2'b00, bpm_q} + {1'b0, bpm_q, 1'b0} + {2'b00, sm_val_q};
    if (sm_go_q) begin
      bpm_d        = bpm_valid_q ? clamp_bpm(NUM_W'(blend_sum[BW+1:2])) : sm_val_q;
      bpm_valid_d  = 1'b1;
      bpm_update_d = 1'b1;
    end
`else
    if (div_done) begin
      bpm_d        = clamp_bpm(div_quot);
      bpm_valid_d  = 1'b1;
      bpm_update_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      tick_cnt_q     <= '0;
      interval_cnt_q <= '0;
      peak_q         <= '0;
      pulse_amp_q    <= '0;
      beat_pulse_q   <= 1'b0;
      div_start_q    <= 1'b0;
      div_den_q      <= '0;
      bpm_q          <= '0;
      bpm_valid_q    <= 1'b0;
      bpm_update_q   <= 1'b0;
      mag_ready_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      interval_cnt_q <= interval_cnt_d;
      peak_q         <= peak_d;
      pulse_amp_q    <= pulse_amp_d;
      beat_pulse_q   <= beat_pulse_d;
      div_start_q    <= div_start_d;
      div_den_q      <= div_den_d;
      bpm_q          <= bpm_d;
      bpm_valid_q    <= bpm_valid_d;
      bpm_update_q   <= bpm_update_d;
      mag_ready_q    <= 1'b1;
    end
  end

`ifdef BEAT_BPM_SMOOTH_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sm_go_q  <= 1'b0;
      sm_val_q <= '0;
    end else begin
      sm_go_q  <= sm_go_d;
      sm_val_q <= sm_val_d;
    end
  end
`endif

  assign mag_ready       = mag_ready_q;
  assign BPM_estimate    = bpm_q;
  assign bpm_valid       = bpm_valid_q;
  assign pulse_amplitude = pulse_amp_q;
  assign beat_pulse      = beat_pulse_q;
  assign bpm_update      = bpm_update_q;

endmodule

// File: tb/tb_beat_bpm_estimator.sv
// Scoreboard bench for beat_bpm_estimator with a 4-cycle tick; onsets are spaced
// 4*T+1 cycles apart so the measured interval is exactly T ticks at any tick phase.
module tb_beat_bpm_estimator;
  import beat_pkg::*;

  localparam int TICK = 4;
`ifdef BEAT_BPM_SMOOTH_EN
  localparam int LAT = DIV_LATENCY + 1;
`else
  localparam int LAT = DIV_LATENCY;
`endif

  typedef struct {
    int cyc;
    int bpm;
  } upd_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] mag_in;
  logic       mag_valid;
  logic       mag_ready;
  logic [7:0] BPM_estimate;
  logic       bpm_valid;
  logic [7:0] pulse_amplitude;
  logic       beat_pulse;
  logic       bpm_update;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_onset = 0;
  int   model_bpm = 0;
  bit   model_valid = 1'b0;
  int   exp_beat[$];
  int   obs_beat[$];
  upd_t exp_upd[$];
  upd_t obs_upd[$];
  upd_t none_upd = '{-1, -1};

  always #5 clk = ~clk;

  beat_bpm_estimator #(
    .TICK_DIV (TICK)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .mag_in          (mag_in),
    .mag_valid       (mag_valid),
    .mag_ready       (mag_ready),
    .BPM_estimate    (BPM_estimate),
    .bpm_valid       (bpm_valid),
    .pulse_amplitude (pulse_amplitude),
    .beat_pulse      (beat_pulse),
    .bpm_update      (bpm_update)
  );

  function automatic int clamp_i(input int v);
    if (v < 40) return 40;
    if (v > 200) return 200;
    return v;
  endfunction

  // One sample per cycle; records strobes seen just after the capturing edge.
  task automatic step(input logic [7:0] v, input logic vld = 1'b1);
    upd_t u;
    @(negedge clk);
    mag_in = v;
    mag_valid = vld;
    @(posedge clk);
    cyc++;
    #1;
    if (beat_pulse) obs_beat.push_back(cyc);
    if (bpm_update) begin
      u.cyc = cyc;
      u.bpm = int'(BPM_estimate);
      obs_upd.push_back(u);
    end
  endtask

  // Pads with quiet samples so the onset lands T ticks after the last accepted one.
  task automatic onset(input int t, input logic [7:0] v, input bit accept, input bit divide);
    upd_t u;
    int q;
    while (cyc + 1 < last_onset + TICK * t + 1) step(8'd50);
    step(v);
    if (accept) begin
      exp_beat.push_back(cyc);
      last_onset = cyc;
      if (divide) begin
        q = clamp_i(15000 / t);
`ifdef BEAT_BPM_SMOOTH_EN
        model_bpm = model_valid ? clamp_i((3 * model_bpm + q) >> 2) : q;
`else
        model_bpm = q;
`endif
        model_valid = 1'b1;
        u.cyc = cyc + LAT;
        u.bpm = model_bpm;
        exp_upd.push_back(u);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mag_in = 8'd0;
    mag_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mag_ready, bpm_valid, beat_pulse, bpm_update} !== 4'b0000 || BPM_estimate !== 8'd0 || pulse_amplitude !== 8'd0)
      begin errors++; $display("FAIL reset_outputs: ready=%b valid=%b bpm=%0d amp=%0d, required all 0", mag_ready, bpm_valid, BPM_estimate, pulse_amplitude); end
    @(negedge clk);
    reset = 1'b1;
    step(8'd255, 1'b0);
    step(8'd255, 1'b0);
    checks++;
    if (mag_ready !== 1'b1) begin errors++; $display("FAIL mag_ready: got %b, required 1", mag_ready); end
    checks++;
    if (bpm_valid !== 1'b0 || BPM_estimate !== 8'd0) begin errors++; $display("FAIL post_reset_bpm: valid=%b bpm=%0d, required 0/0", bpm_valid, BPM_estimate); end
  endtask

  task automatic test_tempo();
    int e, o;
    upd_t eu, ou;
    step(8'd200);
    step(8'd50, 1'b0);
    step(8'd200);
    step(8'd50);
    onset(0, 8'd180, 1'b1, 1'b0);
    onset(150, 8'd180, 1'b1, 1'b1);
    onset(75, 8'd180, 1'b1, 1'b1);
    onset(375, 8'd180, 1'b1, 1'b1);
    repeat (LAT + 1) step(8'd50);
    checks++;
    if (bpm_valid !== 1'b1 || int'(BPM_estimate) != model_bpm)
      begin errors++; $display("FAIL tempo_max_ticks: valid=%b bpm=%0d, required 1/%0d", bpm_valid, BPM_estimate, model_bpm); end
    onset(60, 8'd180, 1'b0, 1'b0);
    onset(150, 8'd180, 1'b1, 1'b1);
    repeat (LAT + 4) step(8'd50);
    while (exp_beat.size() + obs_beat.size() > 0) begin
      e = (exp_beat.size() > 0) ? exp_beat.pop_front() : -1;
      o = (obs_beat.size() > 0) ? obs_beat.pop_front() : -1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL tempo_beat: beat_pulse at cycle %0d, required %0d", o, e); end
    end
    while (exp_upd.size() + obs_upd.size() > 0) begin
      eu = (exp_upd.size() > 0) ? exp_upd.pop_front() : none_upd;
      ou = (obs_upd.size() > 0) ? obs_upd.pop_front() : none_upd;
      checks++;
      if (ou.cyc !== eu.cyc || ou.bpm !== eu.bpm)
        begin errors++; $display("FAIL tempo_update: cycle %0d bpm %0d, required cycle %0d bpm %0d", ou.cyc, ou.bpm, eu.cyc, eu.bpm); end
    end
    checks++;
    if (pulse_amplitude !== 8'd180) begin errors++; $display("FAIL tempo_amp: got %0d, required 180", pulse_amplitude); end
  endtask

  task automatic test_amplitude();
    int e, o;
    upd_t eu, ou;
    onset(100, 8'd130, 1'b1, 1'b1);
    step(8'd200);
    step(8'd170);
    step(8'd110);
    step(8'd100);
    step(8'd127);
    checks++;
    if (pulse_amplitude !== 8'd180) begin errors++; $display("FAIL amp_band: got %0d, required 180 (beat still open)", pulse_amplitude); end
    step(8'd90);
    checks++;
    if (pulse_amplitude !== 8'd200) begin errors++; $display("FAIL amp_peak: got %0d, required 200", pulse_amplitude); end
    repeat (LAT) step(8'd50);
    while (exp_beat.size() + obs_beat.size() > 0) begin
      e = (exp_beat.size() > 0) ? exp_beat.pop_front() : -1;
      o = (obs_beat.size() > 0) ? obs_beat.pop_front() : -1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL amp_beat: beat_pulse at cycle %0d, required %0d", o, e); end
    end
    while (exp_upd.size() + obs_upd.size() > 0) begin
      eu = (exp_upd.size() > 0) ? exp_upd.pop_front() : none_upd;
      ou = (obs_upd.size() > 0) ? obs_upd.pop_front() : none_upd;
      checks++;
      if (ou.cyc !== eu.cyc || ou.bpm !== eu.bpm)
        begin errors++; $display("FAIL amp_update: cycle %0d bpm %0d, required cycle %0d bpm %0d", ou.cyc, ou.bpm, eu.cyc, eu.bpm); end
    end
  endtask

  task automatic test_timeout();
    int e, o;
    upd_t eu, ou;
    onset(100, 8'd255, 1'b1, 1'b1);
    repeat (TICK * 377 + 8) step(8'd255);
    model_valid = 1'b0;
    checks++;
    if (bpm_valid !== 1'b0) begin errors++; $display("FAIL timeout_valid: got %b, required 0", bpm_valid); end
    checks++;
    if (int'(BPM_estimate) != model_bpm) begin errors++; $display("FAIL timeout_hold: bpm %0d, required %0d", BPM_estimate, model_bpm); end
    checks++;
    if (pulse_amplitude !== 8'd200) begin errors++; $display("FAIL timeout_amp: got %0d, required 200", pulse_amplitude); end
    step(8'd50);
    onset(0, 8'd255, 1'b1, 1'b0);
    repeat (LAT + 4) step(8'd50);
    while (exp_beat.size() + obs_beat.size() > 0) begin
      e = (exp_beat.size() > 0) ? exp_beat.pop_front() : -1;
      o = (obs_beat.size() > 0) ? obs_beat.pop_front() : -1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL timeout_beat: beat_pulse at cycle %0d, required %0d", o, e); end
    end
    while (exp_upd.size() + obs_upd.size() > 0) begin
      eu = (exp_upd.size() > 0) ? exp_upd.pop_front() : none_upd;
      ou = (obs_upd.size() > 0) ? obs_upd.pop_front() : none_upd;
      checks++;
      if (ou.cyc !== eu.cyc || ou.bpm !== eu.bpm)
        begin errors++; $display("FAIL timeout_update: cycle %0d bpm %0d, required cycle %0d bpm %0d", ou.cyc, ou.bpm, eu.cyc, eu.bpm); end
    end
    checks++;
    if (bpm_valid !== 1'b0) begin errors++; $display("FAIL rearm_valid: got %b, required 0", bpm_valid); end
  endtask

  task automatic test_reset_mid_divide();
    int e, o;
    upd_t eu, ou;
    onset(150, 8'd180, 1'b1, 1'b0);
    repeat (4) step(8'd50);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    model_valid = 1'b0;
    model_bpm = 0;
    checks++;
    if ({mag_ready, bpm_valid, beat_pulse, bpm_update} !== 4'b0000 || BPM_estimate !== 8'd0 || pulse_amplitude !== 8'd0)
      begin errors++; $display("FAIL mid_reset_outputs: ready=%b valid=%b bpm=%0d amp=%0d, required all 0", mag_ready, bpm_valid, BPM_estimate, pulse_amplitude); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    step(8'd50);
    onset(0, 8'd200, 1'b1, 1'b0);
    repeat (LAT + 4) step(8'd50);
    while (exp_beat.size() + obs_beat.size() > 0) begin
      e = (exp_beat.size() > 0) ? exp_beat.pop_front() : -1;
      o = (obs_beat.size() > 0) ? obs_beat.pop_front() : -1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL mid_reset_beat: beat_pulse at cycle %0d, required %0d", o, e); end
    end
    while (exp_upd.size() + obs_upd.size() > 0) begin
      eu = (exp_upd.size() > 0) ? exp_upd.pop_front() : none_upd;
      ou = (obs_upd.size() > 0) ? obs_upd.pop_front() : none_upd;
      checks++;
      if (ou.cyc !== eu.cyc || ou.bpm !== eu.bpm)
        begin errors++; $display("FAIL mid_reset_update: cycle %0d bpm %0d, required cycle %0d bpm %0d", ou.cyc, ou.bpm, eu.cyc, eu.bpm); end
    end
    checks++;
    if (bpm_valid !== 1'b0 || BPM_estimate !== 8'd0) begin errors++; $display("FAIL mid_reset_bpm: valid=%b bpm=%0d, required 0/0", bpm_valid, BPM_estimate); end
  endtask

`ifdef BEAT_BPM_SMOOTH_EN
  task automatic test_smooth();
    int e, o;
    upd_t eu, ou;
    onset(150, 8'd180, 1'b1, 1'b1);
    onset(75, 8'd180, 1'b1, 1'b1);
    repeat (LAT + 4) step(8'd50);
    checks++;
    if (BPM_estimate !== 8'd125) begin errors++; $display("FAIL smooth_blend: bpm %0d, required 125", BPM_estimate); end
    while (exp_beat.size() + obs_beat.size() > 0) begin
      e = (exp_beat.size() > 0) ? exp_beat.pop_front() : -1;
      o = (obs_beat.size() > 0) ? obs_beat.pop_front() : -1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL smooth_beat: beat_pulse at cycle %0d, required %0d", o, e); end
    end
    while (exp_upd.size() + obs_upd.size() > 0) begin
      eu = (exp_upd.size() > 0) ? exp_upd.pop_front() : none_upd;
      ou = (obs_upd.size() > 0) ? obs_upd.pop_front() : none_upd;
      checks++;
      if (ou.cyc !== eu.cyc || ou.bpm !== eu.bpm)
        begin errors++; $display("FAIL smooth_update: cycle %0d bpm %0d, required cycle %0d bpm %0d", ou.cyc, ou.bpm, eu.cyc, eu.bpm); end
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_tempo();
    test_amplitude();
    test_timeout();
    test_reset_mid_divide();
`ifdef BEAT_BPM_SMOOTH_EN
    test_smooth();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/beat_bpm_estimator.md
Name: beat_bpm_estimator

Overview:
Producer end of the ADSR filter's control interface. Consumes a per-sample audio magnitude stream and detects beat onsets with hysteresis and a refractory window. It measures the onset-to-onset interval in 4 ms ticks and converts it to BPM with a sequential divider. It publishes BPM_estimate and pulse_amplitude, plus strobes, for the pixel filter.

Parameters:
BITS, 8, magnitude and pulse_amplitude width
MIN_BPM, 40, slowest accepted tempo; sets timeout
MAX_BPM, 200, fastest accepted tempo; sets refractory window
TICK_DIV, 200_000, clk cycles per tick (4 ms at 50 MHz)
TICKS_PER_MIN, 15000, ticks per minute; divider dividend
THRESH_HI, 128, onset threshold (mag_in >= THRESH_HI)
THRESH_LO, 96, release threshold (mag_in < THRESH_LO); must be <= THRESH_HI

Ports:
clk  input  1  system clock
reset  input  1  reset, asynchronous, active-low
mag_in  input  BITS  audio magnitude sample
mag_valid  input  1  mag_in qualifier
mag_ready  output  1  always 1 after reset; the block never back-pressures
BPM_estimate  output  $clog2(MAX_BPM+1)  latest tempo, clamped to [MIN_BPM, MAX_BPM]
bpm_valid  output  1  BPM_estimate is current
pulse_amplitude  output  BITS  peak mag_in of the last completed beat
beat_pulse  output  1  one-cycle strobe on each accepted onset
bpm_update  output  1  one-cycle strobe when BPM_estimate is rewritten

Behaviour:
- Reset (asserted low, async): all outputs 0 except mag_ready = 0 while reset is asserted. FSM goes to S_IDLE; tick counter, interval counter, peak register and divider clear.
- Tick: tick_cnt counts 0..TICK_DIV-1. tick is high for one cycle at wrap. interval_cnt increments on tick and saturates at MAX_TICKS+1.
- Derived constants: MIN_TICKS = TICKS_PER_MIN/MAX_BPM (75); MAX_TICKS = TICKS_PER_MIN/MIN_BPM (375).
- FSM transitions are evaluated only on cycles with mag_valid = 1; the tick and timeout run every cycle.
  - S_IDLE: no reference beat; waits for the signal to go quiet. mag_in < THRESH_LO -> S_ARM.
  - S_ARM: mag_in >= THRESH_HI -> first onset. beat_pulse = 1, interval_cnt = 0, peak = mag_in, -> S_HIGH. No divide.
  - S_LOW: mag_in >= THRESH_HI with interval_cnt >= MIN_TICKS -> accepted onset. beat_pulse = 1, interval latched, interval_cnt = 0, divider started, peak = mag_in, -> S_HIGH. With interval_cnt < MIN_TICKS: onset ignored, stay in S_LOW, interval keeps counting.
  - S_HIGH: peak = max(peak, mag_in). mag_in < THRESH_LO -> pulse_amplitude <= peak, -> S_LOW.
- beat_pulse is registered: high the cycle after the qualifying sample.
- Timeout: interval_cnt reaching MAX_TICKS+1 in S_LOW or S_HIGH -> bpm_valid = 0, -> S_IDLE. BPM_estimate and pulse_amplitude hold their values. An interval of exactly MAX_TICKS is valid.
- Divider:
  - Restoring, unsigned, 14-bit dividend / 9-bit divisor.
  - Fixed latency: BPM_estimate, bpm_valid = 1 and bpm_update are all visible exactly 16 cycles after beat_pulse.
  - Result is clamped to [MIN_BPM, MAX_BPM].
  - A start request while busy cannot occur, because MIN_TICKS*TICK_DIV >> 16. If it does, it is ignored.
- Simultaneous tick and onset on the same cycle: the latched interval excludes that tick, and interval_cnt restarts at 0.
- Reset mid-divide aborts the divide; no bpm_update is produced.
- Widths: interval 9 bits plus a saturate bit; all comparisons unsigned.

Optional Feature:
- Macro: BEAT_BPM_SMOOTH_EN.
- Defined: each new quotient q is blended as BPM_estimate <= (3*BPM_estimate + q) >> 2, computed in 10 bits and clamped.
  - The first estimate after reset or timeout loads q directly.
  - Adds one cycle, so the total latency is 17 cycles after beat_pulse.
- Undefined: BPM_estimate <= clamped q with 16-cycle latency.

Decomposition:
- Package beat_pkg:
  - state enum {S_IDLE, S_ARM, S_LOW, S_HIGH}
  - functions computing MIN_TICKS and MAX_TICKS
  - localparam DIV_LATENCY = 16
- Sub-module bpm_divider:
  - parameters NUM_W = 14, DEN_W = 9
  - ports start, num, den, busy, done, quot
  - fixed iteration count; divide-by-0 returns all-ones

Test Plan:
- TICK_DIV = 4: 200, then low 50, then onsets 150 ticks apart -> beat_pulse each onset; BPM_estimate = 100 and bpm_update exactly 16 cycles after the 2nd beat_pulse.
- Onsets 75 ticks apart -> 200. Onsets 375 ticks apart -> 40, bpm_valid = 1. Onset at 60 ticks -> no beat_pulse; a later onset at 150 ticks -> 100.
- Samples 130, 200, 170, 90 in S_HIGH -> pulse_amplitude = 200 on the 90 sample. Values 100 to 127 (inside the hysteresis band) do not end the beat.
- No onset for 376 ticks -> bpm_valid = 0, state S_IDLE, BPM_estimate held. A constant mag 255 gives no beat until mag < 96, then onset.
- Assert reset 5 cycles after beat_pulse -> all outputs 0 immediately, no bpm_update. After release, the first onset is not followed by an estimate.
- With BEAT_BPM_SMOOTH_EN: estimates 100 then q = 200 -> 125 at 17 cycles after beat_pulse.
